// File: rtl/adc_ram_capture_writer_pkg.sv
// Shared types and constants for the ADC capture writer.
package adc_ram_capture_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } cap_state_e;

  // Each packed sample occupies one 16-bit half of a RAM word.
  localparam int unsigned SAMPLE_HALF_W = 16;

  // All four byte lanes are written on every transfer.
  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

  // Word address to byte address.
  localparam int unsigned BYTE_ADDR_SHIFT = 2;

endpackage

// File: rtl/capture_word_fifo.sv
// Synchronous show-ahead FIFO for packed sample words. The head entry is
// always visible on data_o; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module capture_word_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since empty_o gates their use.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/adc_ram_capture_writer.sv
// Avalon-MM write master that packs ADC sample pairs into 32-bit words and
// streams a triggered capture of programmable length into the sample RAM.
module adc_ram_capture_writer
  import adc_ram_capture_writer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DEPTH_WORDS = 393216,
  parameter int unsigned SAMPLE_W    = 14,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                arm,
  input  logic                trig,
  input  logic [ADDR_W:0]     length_words,
  output logic [ADDR_W+1:0]   avm_address,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic                avm_waitrequest,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     words_written
);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);

  cap_state_e               state_q;
  logic                     busy_q;
  logic                     done_q;
  logic [ADDR_W:0]          len_q;
  logic [ADDR_W:0]          push_cnt_q;
  logic                     phase_q;
  logic [SAMPLE_HALF_W-1:0] lo_q;
  logic [ADDR_W-1:0]        word_addr_q;
  logic [ADDR_W:0]          words_written_q;
  logic                     overflow_q;

  logic [ADDR_W:0]          len_clamped;
  logic [ADDR_W:0]          push_cnt_inc;
  logic [SAMPLE_HALF_W-1:0] sample_ext;
  logic [31:0]              push_word;
  logic                     arm_ok;
  logic                     start;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic [31:0]              fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;

  assign len_clamped  = (length_words > DEPTH_L) ? DEPTH_L : length_words;
  assign push_cnt_inc = push_cnt_q + 1'b1;
  assign sample_ext   = SAMPLE_HALF_W'(adc_data);
  assign push_word    = {sample_ext, lo_q};

  assign arm_ok = arm && (state_q == ST_IDLE || state_q == ST_DONE);
  assign start  = (state_q == ST_ARMED) && trig;
  // The trigger-cycle sample is the first sample of the capture, unless the
  // capture is empty and goes straight to DONE.
  assign accept = adc_valid &&
                  ((state_q == ST_CAPTURE) || (start && len_clamped != '0));
  assign push   = accept && phase_q;
  assign pop    = !fifo_empty && !avm_waitrequest;
  assign drop   = push && fifo_full && !pop;

  capture_word_fifo #(
    .WIDTH      (32),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_capture_word_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            if (len_clamped == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (push && push_cnt_inc == len_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Packing, push accounting, write address and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q           <= '0;
      push_cnt_q      <= '0;
      phase_q         <= 1'b0;
      lo_q            <= '0;
      word_addr_q     <= '0;
      words_written_q <= '0;
      overflow_q      <= 1'b0;
    end else if (arm_ok) begin
      push_cnt_q      <= '0;
      phase_q         <= 1'b0;
      word_addr_q     <= '0;
      words_written_q <= '0;
      overflow_q      <= 1'b0;
    end else begin
      if (start) len_q <= len_clamped;
      if (accept) begin
        phase_q <= ~phase_q;
        if (!phase_q) lo_q <= sample_ext;
      end
      // Dropped words still count so the capture ends after 2*len samples.
      if (push) push_cnt_q <= push_cnt_inc;
      if (drop) overflow_q <= 1'b1;
      if (pop) begin
        word_addr_q     <= (word_addr_q == LAST_ADDR) ? '0 : word_addr_q + 1'b1;
        words_written_q <= words_written_q + 1'b1;
      end
    end
  end

  assign avm_write      = !fifo_empty;
  assign avm_writedata  = fifo_empty ? '0 : fifo_head;
  assign avm_byteenable = fifo_empty ? 4'h0 : BYTEENABLE_ALL;
  assign avm_address    = (ADDR_W + 2)'(word_addr_q) << BYTE_ADDR_SHIFT;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign words_written  = words_written_q;

endmodule
